// File: rtl/gpio_stream_bridge.sv
// rtl/gpio_stream_bridge.sv - mprj_io pin stream endpoint: 8-bit pins in, 16-bit pins out.
// Pin FIFOs decouple the off-chip handshakes from the core's AXI4-Stream ports.

module gpio_stream_bridge_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q, count;

  assign count        = wptr_q - rptr_q;
  assign empty_o      = (wptr_q == rptr_q);
  assign full_o       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_next_o = count + (AW+1)'(push_i) - (AW+1)'(pop_i);
  assign data_o       = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= data_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));
endmodule

module gpio_stream_bridge #(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 16,
  parameter int IFIFO_DEPTH = 4,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [37:0]      io_in,
  output logic [37:0]      io_out,
  output logic [37:0]      io_oeb,
  output logic [IN_W-1:0]  m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  input  logic [OUT_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready
);
  localparam int IA = $clog2(IFIFO_DEPTH);
  localparam int OA = $clog2(OFIFO_DEPTH);

  logic              in_ready_q;
  logic [IN_W-1:0]   in_data;
  logic              in_push, ififo_empty, ififo_full_unused;
  logic [IA:0]       ififo_count_next;

  logic              s_ready_en_q;
  logic              ofifo_push, ofifo_pop, ofifo_empty, ofifo_full;
  logic [OA:0]       ofifo_count_unused;
  logic [OUT_W:0]    ofifo_head;

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              io_in_unused;

  assign io_in_unused = ^{io_in[25:0], io_in[27]};

  // Pad 37 carries bit 0 of the incoming byte.
  always_comb begin
    in_data = '0;
    for (int i = 0; i < IN_W; i++) in_data[i] = io_in[37-i];
  end

  assign in_push = in_ready_q && io_in[28];

  gpio_stream_bridge_fifo #(.W(IN_W+1), .DEPTH(IFIFO_DEPTH)) u_ififo (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .push_i       (in_push),
    .data_i       ({io_in[29], in_data}),
    .pop_i        (m_axis_tvalid && m_axis_tready),
    .data_o       ({m_axis_tlast, m_axis_tdata}),
    .empty_o      (ififo_empty),
    .full_o       (ififo_full_unused),
    .count_next_o (ififo_count_next)
  );

  assign m_axis_tvalid = !ififo_empty;

  assign s_axis_tready = s_ready_en_q && !ofifo_full;
  assign ofifo_push    = s_axis_tvalid && s_axis_tready;

  gpio_stream_bridge_fifo #(.W(OUT_W+1), .DEPTH(OFIFO_DEPTH)) u_ofifo (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .push_i       (ofifo_push),
    .data_i       ({s_axis_tlast, s_axis_tdata}),
    .pop_i        (ofifo_pop),
    .data_o       (ofifo_head),
    .empty_o      (ofifo_empty),
    .full_o       (ofifo_full),
    .count_next_o (ofifo_count_unused)
  );

  // The pin slice refills whenever it is empty or its beat is being taken.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    ofifo_pop   = 1'b0;
    if (!out_valid_q || io_in[26]) begin
      if (!ofifo_empty) begin
        ofifo_pop                = 1'b1;
        out_valid_d              = 1'b1;
        {out_last_d, out_data_d} = ofifo_head;
      end else if (io_in[26]) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      in_ready_q   <= 1'b0;
      s_ready_en_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      in_ready_q   <= (ififo_count_next != (IA+1)'(IFIFO_DEPTH));
      s_ready_en_q <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  always_comb begin
    io_out         = '0;
    io_out[23:8]   = out_data_q;
    io_out[24]     = out_last_q;
    io_out[25]     = out_valid_q;
    io_out[27]     = in_ready_q;
  end

  assign io_oeb = {10'h3FF, 1'b0, 1'b1, 18'h0, 8'hFF};
endmodule

// File: tb/tb_gpio_stream_bridge.sv
// tb/tb_gpio_stream_bridge.sv - queue-model scoreboard bench for gpio_stream_bridge.
module tb_gpio_stream_bridge;
  localparam int ID = 4;
  localparam int OD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] io_in = '0;
  logic [37:0] io_out, io_oeb;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic        s_tready;

  always #5 clk = ~clk;

  gpio_stream_bridge dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .io_in         (io_in),
    .io_out        (io_out),
    .io_oeb        (io_oeb),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready)
  );

  int total = 0, passed = 0, cyc = 0, first_hs, first_ov;
  logic [8:0]  in_src[$], iq[$], m_got[$];
  logic [16:0] out_src[$], oq[$], pin_got[$], sent[$];
  bit          exp_in_ready, exp_en, sv, sl;
  logic [15:0] sd;
  bit          in_gate, out_gate, tready_m, oready, rand_mode;
  logic [37:0] exp_oeb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_pins(input bit v, input bit l, input logic [7:0] d, input bit ordy);
    io_in        = '0;
    io_in[25:0]  = 26'($urandom);
    io_in[27]    = 1'($urandom);
    io_in[26]    = ordy;
    io_in[28]    = v;
    io_in[29]    = l;
    for (int i = 0; i < 8; i++) io_in[37-i] = d[i];
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", io_out[27], 0);
    check("rst_out_valid", io_out[25], 0);
    check("rst_out_data", io_out[23:8], 0);
    check("rst_out_last", io_out[24], 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_io_oeb", io_oeb, exp_oeb);
  endtask

  task automatic clear_model();
    iq.delete(); oq.delete(); in_src.delete(); out_src.delete();
    exp_in_ready = 0; exp_en = 0; sv = 0; sl = 0; sd = '0;
  endtask

  // One clock: caller is just after a negedge; returns just after the next one.
  task automatic cycle();
    bit iv, exp_sr;
    logic [8:0] ih;
    if (rand_mode) begin
      in_gate  = 1'($urandom); out_gate = 1'($urandom);
      tready_m = 1'($urandom); oready   = 1'($urandom);
      if (in_src.size() < 2) in_src.push_back(9'($urandom));
      if (out_src.size() < 2) out_src.push_back(17'($urandom));
    end
    iv = in_gate && (in_src.size() != 0);
    ih = (in_src.size() != 0) ? in_src[0] : 9'($urandom);
    drive_pins(iv, ih[8], ih[7:0], oready);
    m_tready = tready_m;
    s_tvalid = out_gate && (out_src.size() != 0);
    {s_tlast, s_tdata} = s_tvalid ? out_src[0] : 17'($urandom);
    #1;
    exp_sr = exp_en && (oq.size() != OD);
    check("in_ready", io_out[27], exp_in_ready);
    check("m_tvalid", m_tvalid, iq.size() != 0);
    if (iq.size() != 0) begin
      check("m_tdata", m_tdata, iq[0][7:0]);
      check("m_tlast", m_tlast, iq[0][8]);
    end
    check("s_tready", s_tready, exp_sr);
    check("out_valid", io_out[25], sv);
    if (sv) begin
      check("out_data", io_out[23:8], sd);
      check("out_last", io_out[24], sl);
    end
    check("io_oeb", io_oeb, exp_oeb);
    check("io_out_unused", io_out & exp_oeb, 0);
    if (s_tvalid && s_tready && first_hs < 0) first_hs = cyc;
    if (io_out[25] && first_ov < 0) first_ov = cyc;

    if (iq.size() != 0 && tready_m) begin
      m_got.push_back({m_tlast, m_tdata});
      void'(iq.pop_front());
    end
    if (exp_in_ready && iv) begin
      iq.push_back(ih);
      void'(in_src.pop_front());
    end
    exp_in_ready = (iq.size() != ID);

    if (sv && oready) pin_got.push_back({io_out[24], io_out[23:8]});
    if (!sv || oready) begin
      if (oq.size() != 0) begin
        {sl, sd} = oq.pop_front();
        sv = 1;
      end else if (oready) sv = 0;
    end
    if (s_tvalid && exp_sr) begin
      oq.push_back(out_src[0]);
      sent.push_back(out_src[0]);
      void'(out_src.pop_front());
    end
    exp_en = 1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 38; i++)
      exp_oeb[i] = !((i >= 8 && i <= 25) || i == 27);
    clear_model();
    {in_gate, out_gate, tready_m, oready, rand_mode} = '0;

    // Reset held with the clock running, then released.
    repeat (2) @(negedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    repeat (3) cycle();

    // Directed bytes; pad 37 alone high gives 0x01.
    m_got.delete();
    in_src = '{9'h001, 9'h002, 9'h003, 9'h180};
    in_gate = 1; tready_m = 1;
    repeat (10) cycle();
    check("dir_in_count", m_got.size(), 4);
    if (m_got.size() == 4) begin
      check("dir_in_0", m_got[0], 9'h001);
      check("dir_in_1", m_got[1], 9'h002);
      check("dir_in_2", m_got[2], 9'h003);
      check("dir_in_3", m_got[3], 9'h180);
    end

    // Input backpressure: fill, release tready one cycle, refill.
    tready_m = 0;
    for (int i = 0; i < 8; i++) in_src.push_back(9'($urandom));
    repeat (8) cycle();
    check("bp_accepted", in_src.size(), 4);
    tready_m = 1; cycle();
    tready_m = 0; repeat (4) cycle();
    check("bp_one_more", in_src.size(), 3);
    tready_m = 1; repeat (12) cycle();
    in_gate = 0;

    // Output burst with steady out_ready.
    pin_got.delete(); sent.delete();
    first_hs = -1; first_ov = -1;
    for (int i = 1; i <= 8; i++) out_src.push_back({(i == 8), 16'(i)});
    out_gate = 1; oready = 1;
    repeat (14) cycle();
    check("burst_latency", first_ov - first_hs, 2);
    check("burst_count", pin_got.size(), 8);
    for (int i = 0; i < pin_got.size(); i++)
      check("burst_beat", pin_got[i], {(i == 7), 16'(i + 1)});

    // out_ready 1,0,0,1 pattern while the FIFO fills.
    pin_got.delete(); sent.delete();
    for (int i = 0; i < 10; i++) out_src.push_back(17'($urandom));
    for (int c = 0; c < 40; c++) begin
      oready = (c % 4 == 0) || (c % 4 == 3);
      if (c < 3) oready = 0;
      cycle();
    end
    oready = 1; repeat (8) cycle();
    check("toggle_count", pin_got.size(), 10);
    for (int i = 0; i < pin_got.size() && i < sent.size(); i++)
      check("toggle_beat", pin_got[i], sent[i]);

    // Randomized traffic on both paths.
    rand_mode = 1;
    repeat (400) cycle();
    rand_mode = 0;
    in_src.delete(); out_src.delete();
    tready_m = 1; oready = 1;
    repeat (12) cycle();

    // Asynchronous reset mid-burst on both paths.
    for (int i = 0; i < 6; i++) begin
      in_src.push_back(9'($urandom));
      out_src.push_back(17'($urandom));
    end
    in_gate = 1; out_gate = 1; tready_m = 0; oready = 0;
    repeat (4) cycle();
    #2 rst = 1'b1;
    #1;
    check_reset_values();
    clear_model();
    drive_pins(0, 0, 8'h00, 0);
    s_tvalid = 0;
    @(negedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    m_got.delete(); pin_got.delete();
    in_src.push_back(9'h0AA);
    out_src.push_back(17'h01234);
    tready_m = 1; oready = 1;
    repeat (10) cycle();
    check("post_in_count", m_got.size(), 1);
    if (m_got.size() != 0) check("post_in_data", m_got[0], 9'h0AA);
    check("post_out_count", pin_got.size(), 1);
    if (pin_got.size() != 0) check("post_out_data", pin_got[0], 17'h01234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
